// File: rtl/ace_snoop_initiator.sv
// ace_snoop_initiator
//   Interconnect-side ACE snoop master. It accepts one snoop request at a time
//   from the coherency controller and issues it on the AC channel. It then
//   collects the CR response. When the response indicates a data transfer, it
//   forwards the CD beats downstream on the md_* port. Completion is reported
//   with a one-cycle done pulse.
//
//   Optional feature (macro ACE_SNOOP_TIMEOUT_EN): a watchdog counter limits the
//   CR and CD waits to TIMEOUT_CYC cycles. Without the macro, both waits are
//   unbounded.
//
// Ports
//   clk, rst_n                       clock (rising edge), async active-low reset
//   req_valid/req_ready              request handshake
//   req_addr, req_snoop              request address and snoop type
//   acvalid/acready, acaddr, acsnoop AC snoop address channel
//   crvalid/crready, crresp          CR snoop response channel
//   cdvalid/cdready, cddata, cdlast  CD snoop data channel
//   md_valid/md_ready, md_data       forwarded data beats (pass-through of CD)
//   done, done_resp, done_err        completion pulse, captured response, error
//   busy                             high whenever a snoop is in flight
module ace_snoop_initiator #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int CD_BEATS    = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_snoop,
    output logic              acvalid,
    input  logic              acready,
    output logic [ADDR_W-1:0] acaddr,
    output logic [3:0]        acsnoop,
    input  logic              crvalid,
    output logic              crready,
    input  logic [4:0]        crresp,
    input  logic              cdvalid,
    output logic              cdready,
    input  logic [DATA_W-1:0] cddata,
    input  logic              cdlast,
    output logic              md_valid,
    input  logic              md_ready,
    output logic [DATA_W-1:0] md_data,
    output logic              done,
    output logic [4:0]        done_resp,
    output logic              done_err,
    output logic              busy
);

    localparam int CNT_W = (CD_BEATS > 1) ? $clog2(CD_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CD_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AC,
        S_CR,
        S_CD,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_out_en;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_snoop;
    logic [4:0]        r_resp;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic              r_err;

    logic w_accept;
    logic w_ac_hs;
    logic w_cr_hs;
    logic w_cd_hs;
    logic w_cd_end;
    logic w_cd_bad;
    logic w_timeout;

    // r_out_en keeps req_ready low while reset is asserted, even though the
    // state register already sits in IDLE.
    assign w_accept = (r_state == S_IDLE) && r_out_en && req_valid;
    assign w_ac_hs  = (r_state == S_AC) && acready;
    assign w_cr_hs  = (r_state == S_CR) && crvalid;
    assign w_cd_hs  = (r_state == S_CD) && cdvalid && md_ready;
    // A beat ends the line on cdlast or on the last expected beat. The line is
    // malformed when those two disagree.
    assign w_cd_end = w_cd_hs && (cdlast || (r_beat_cnt == LAST_BEAT));
    assign w_cd_bad = w_cd_hs && (cdlast != (r_beat_cnt == LAST_BEAT));

`ifdef ACE_SNOOP_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            w_waiting;

    // Counts idle cycles spent waiting in CR or CD. Any handshake restarts it.
    assign w_waiting = ((r_state == S_CR) && !w_cr_hs) ||
                       ((r_state == S_CD) && !w_cd_hs);
    assign w_timeout = w_waiting && (r_to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (w_waiting && !w_timeout) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end else begin
            r_to_cnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_out_en <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_out_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_snoop    <= '0;
            r_resp     <= '0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= req_addr;
                r_snoop <= req_snoop;
                r_resp  <= '0;
                r_err   <= 1'b0;
            end
            if (w_cr_hs) begin
                r_resp     <= crresp;
                r_beat_cnt <= '0;
            end
            if (w_cd_hs) begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                if (w_cd_bad) begin
                    r_err <= 1'b1;
                end
            end
            // A timeout overrides any response captured earlier.
            if (w_timeout) begin
                r_resp <= 5'b00010;
                r_err  <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        acvalid   = 1'b0;
        acaddr    = r_addr;
        acsnoop   = r_snoop;
        crready   = 1'b0;
        cdready   = 1'b0;
        md_valid  = 1'b0;
        md_data   = '0;
        done      = 1'b0;
        done_resp = '0;
        done_err  = 1'b0;
        busy      = (r_state != S_IDLE);

        unique case (r_state)
            S_IDLE: begin
                req_ready = r_out_en;
                if (w_accept) begin
                    w_next = S_AC;
                end
            end
            S_AC: begin
                acvalid = 1'b1;
                if (w_ac_hs) begin
                    w_next = S_CR;
                end
            end
            S_CR: begin
                crready = 1'b1;
                if (w_cr_hs) begin
                    w_next = crresp[0] ? S_CD : S_DONE;
                end else if (w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_CD: begin
                md_valid = cdvalid;
                md_data  = cddata;
                cdready  = md_ready;
                if (w_cd_end || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                done_resp = r_resp;
                done_err  = r_err | r_resp[1];
                w_next    = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
